// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: scans A and B MSB-first, CHUNK bits per clock.
// Done pulses k cycles after the accepted start; start is ignored while busy.
module serial_mag_comparator #(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 4,
   parameter int SIGNED     = 0,
   parameter int EARLY_EXIT = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [WIDTH-1:0]                     a,
   input  logic [WIDTH-1:0]                     b,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 eq,
   output logic                                 gt,
   output logic                                 lt,
   output logic [$clog2(WIDTH/CHUNK+1)-1:0]     cycles
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = $clog2(NCH + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  sa;
   logic [WIDTH-1:0]  sb;
   logic [CW-1:0]     cnt;
   logic              dec_gt;
   logic              dec_lt;
   logic [CHUNK-1:0]  ca;
   logic [CHUNK-1:0]  cb;
   logic              chunk_gt;
   logic              chunk_lt;
   logic              last_chunk;
   logic              res_gt;
   logic              res_lt;
   logic              load;
   logic              finish;

   // Top chunk of each operand; for signed compare the sign bit is flipped in
   // the first chunk only, turning two's complement into offset binary.
   always_comb begin
      ca = sa[WIDTH-1 -: CHUNK];
      cb = sb[WIDTH-1 -: CHUNK];
      if (SIGNED != 0 && cnt == '0) begin
         ca[CHUNK-1] = ~ca[CHUNK-1];
         cb[CHUNK-1] = ~cb[CHUNK-1];
      end
      chunk_gt   = ca > cb;
      chunk_lt   = ca < cb;
      last_chunk = (cnt == LAST_IDX);
      res_gt     = (dec_gt | dec_lt) ? dec_gt : chunk_gt;
      res_lt     = (dec_gt | dec_lt) ? dec_lt : chunk_lt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (last_chunk || (EARLY_EXIT != 0 && (chunk_gt || chunk_lt))) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb busy = (state == SCAN);

   always_ff @(posedge clk) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         cnt    <= '0;
         dec_gt <= 1'b0;
         dec_lt <= 1'b0;
         done   <= 1'b0;
         eq     <= 1'b0;
         gt     <= 1'b0;
         lt     <= 1'b0;
         cycles <= '0;
      end else begin
         done <= finish;
         if (load) begin
            sa     <= a;
            sb     <= b;
            cnt    <= '0;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
         end else if (state == SCAN) begin
            sa  <= sa << CHUNK;
            sb  <= sb << CHUNK;
            cnt <= cnt + CW'(1);
            // Only the first differing chunk decides; later chunks cannot override.
            if (!(dec_gt | dec_lt)) begin
               dec_gt <= chunk_gt;
               dec_lt <= chunk_lt;
            end
         end
         if (finish) begin
            eq     <= ~(res_gt | res_lt);
            gt     <= res_gt;
            lt     <= res_lt;
            cycles <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench: three comparator variants (unsigned/early, signed/early,
// unsigned/full-scan) driven together and checked against an arithmetic model.
module tb_serial_mag_comparator;

   localparam int W   = 16;
   localparam int C   = 4;
   localparam int NCH = W / C;
   localparam int NI  = 3;
   localparam int BIG = 1 << 30;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  start_v;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  busy_v, done_v, eq_v, gt_v, lt_v;
   logic [2:0]  cyc_v [NI];

   always #5 clk = ~clk;

   serial_mag_comparator #(.WIDTH(W), .CHUNK(C), .SIGNED(0), .EARLY_EXIT(1)) u_us (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b),
      .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0]),
      .cycles(cyc_v[0]));

   serial_mag_comparator #(.WIDTH(W), .CHUNK(C), .SIGNED(1), .EARLY_EXIT(1)) u_sg (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b),
      .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1]),
      .cycles(cyc_v[1]));

   serial_mag_comparator #(.WIDTH(W), .CHUNK(C), .SIGNED(0), .EARLY_EXIT(0)) u_ne (
      .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b),
      .busy(busy_v[2]), .done(done_v[2]), .eq(eq_v[2]), .gt(gt_v[2]), .lt(lt_v[2]),
      .cycles(cyc_v[2]));

   int sgn_p [NI] = '{0, 1, 0};
   int ee_p  [NI] = '{1, 1, 0};

   typedef struct {
      bit          is_rst;
      int          start_e;
      int          end_e;
      logic [5:0]  res;     // {eq, gt, lt, cycles}
   } exp_t;

   exp_t        sbq [NI][$];
   int          free_e [NI];
   logic [5:0]  cur [NI];
   int          edge_n = 0;
   int          checks = 0;
   int          errors = 0;
   int          ndone  = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic exp_t model(input int i, input logic [15:0] av, input logic [15:0] bv,
                                  input int e);
      exp_t x;
      int   k;
      bit   found;
      logic g, l;
      k     = NCH;
      found = 0;
      if (ee_p[i] != 0) begin
         for (int j = 1; j <= NCH; j++) begin
            if (!found && (((av >> (W - C*j)) & 16'hF) != ((bv >> (W - C*j)) & 16'hF))) begin
               k     = j;
               found = 1;
            end
         end
      end
      if (sgn_p[i] != 0) begin
         g = $signed(av) > $signed(bv);
         l = $signed(av) < $signed(bv);
      end else begin
         g = av > bv;
         l = av < bv;
      end
      x.is_rst  = 0;
      x.start_e = e;
      x.end_e   = e + k;
      x.res     = {~(g | l), g, l, 3'(k)};
      return x;
   endfunction

   // Drive one cycle of inputs and record what the next edge should do.
   task automatic cyc(input logic [2:0] st, input logic [15:0] av, input logic [15:0] bv,
                      input logic r);
      int   e;
      exp_t x;
      exp_t t;
      start_v = st;
      a       = av;
      b       = bv;
      rst     = r;
      e       = edge_n + 1;
      for (int i = 0; i < NI; i++) begin
         if (r) begin
            x.is_rst  = 1;
            x.start_e = BIG;
            x.end_e   = e;
            x.res     = '0;
            if (sbq[i].size() > 0) begin
               t = sbq[i][sbq[i].size()-1];
               if (!t.is_rst && t.end_e >= e) begin
                  x.start_e = t.start_e;
                  void'(sbq[i].pop_back());
               end
            end
            sbq[i].push_back(x);
            free_e[i] = e + 1;
         end else if (st[i] && e >= free_e[i]) begin
            x = model(i, av, bv, e);
            sbq[i].push_back(x);
            free_e[i] = x.end_e + 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(3'b000, 16'($urandom), 16'($urandom), 1'b0);
   endtask

   task automatic chk(input string nm, input int i, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d edge %0d: got %h expected %h", nm, i, edge_n, act, exp);
      end
   endtask

   task automatic check_inst(input int i);
      int   n;
      logic ed;
      logic eb;
      exp_t f;
      n  = edge_n;
      ed = 1'b0;
      eb = 1'b0;
      while (sbq[i].size() > 0 && sbq[i][0].end_e < n) begin
         checks++;
         errors++;
         $display("FAIL missed_event inst%0d edge %0d: got none expected event at edge %0d",
                  i, n, sbq[i][0].end_e);
         void'(sbq[i].pop_front());
      end
      if (sbq[i].size() > 0) begin
         f  = sbq[i][0];
         eb = (f.start_e <= n && n < f.end_e);
         if (f.end_e == n) begin
            void'(sbq[i].pop_front());
            ed     = !f.is_rst;
            cur[i] = f.res;
         end
      end
      if (done_v[i]) ndone++;
      chk("done", i, {5'b0, done_v[i]}, {5'b0, ed});
      chk("busy", i, {5'b0, busy_v[i]}, {5'b0, eb});
      chk("result", i, {eq_v[i], gt_v[i], lt_v[i], cyc_v[i]}, cur[i]);
   endtask

   always @(negedge clk) begin
      if (edge_n >= 2) begin
         for (int i = 0; i < NI; i++) check_inst(i);
      end
   end

   initial begin
      logic [15:0] av, bv;
      logic [2:0]  st;
      logic        r;
      rst     = 1'b1;
      start_v = '0;
      a       = '0;
      b       = '0;
      for (int i = 0; i < NI; i++) begin
         free_e[i] = 0;
         cur[i]    = '0;
      end
      @(posedge clk);
      #1;
      cyc(3'b000, 16'h0, 16'h0, 1'b1);
      cyc(3'b000, 16'h0, 16'h0, 1'b1);
      idle(2);

      cyc(3'b111, 16'h1234, 16'h1234, 1'b0); idle(6);
      cyc(3'b111, 16'h8000, 16'h7FFF, 1'b0); idle(6);
      cyc(3'b111, 16'hFFFF, 16'hFFFE, 1'b0); idle(6);
      cyc(3'b111, 16'h12F0, 16'h12F1, 1'b0); idle(6);
      cyc(3'b111, 16'h2000, 16'h1FFF, 1'b0); idle(6);
      cyc(3'b111, 16'hF000, 16'h0000, 1'b0); idle(6);
      cyc(3'b111, 16'hF001, 16'h0002, 1'b0); idle(6);

      // Starts while busy, then a start landing exactly in the done cycle.
      cyc(3'b111, 16'h1111, 16'h1111, 1'b0);
      cyc(3'b111, 16'h9000, 16'h0001, 1'b0);
      cyc(3'b111, 16'h0001, 16'h9000, 1'b0);
      idle(6);
      cyc(3'b111, 16'hAAAA, 16'hAAAA, 1'b0);
      idle(4);
      cyc(3'b111, 16'h5555, 16'h5554, 1'b0);
      idle(6);
      for (int k = 0; k < 20; k++) cyc(3'b111, 16'($urandom), 16'($urandom), 1'b0);
      idle(6);

      // Reset on the second scan edge aborts the compare.
      cyc(3'b111, 16'h1230, 16'h1231, 1'b0);
      cyc(3'b000, 16'h0, 16'h0, 1'b0);
      cyc(3'b000, 16'h0, 16'h0, 1'b1);
      idle(6);
      cyc(3'b111, 16'h0001, 16'h0002, 1'b0);
      idle(6);

      for (int k = 0; k < 1500; k++) begin
         av = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       bv = av;
            1:       bv = av ^ (16'h1 << $urandom_range(0, 15));
            default: bv = 16'($urandom);
         endcase
         st = 3'($urandom);
         r  = ($urandom_range(0, 59) == 0);
         cyc(st, av, bv, r);
      end
      idle(12);

      for (int i = 0; i < NI; i++) begin
         checks++;
         if (sbq[i].size() != 0) begin
            errors++;
            $display("FAIL drain inst%0d: got %0d pending expected 0", i, sbq[i].size());
         end
      end
      checks++;
      if (ndone < 100) begin
         errors++;
         $display("FAIL activity: got %0d done pulses expected at least 100", ndone);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Parametrised multi-cycle magnitude comparator for two WIDTH-bit operands.
- Scans the operands MSB-first, CHUNK bits per clock, under a start/busy/done handshake.
- Supports signed or unsigned compare and optional early exit on the first differing chunk.
- Returns one-hot eq/gt/lt flags plus the number of chunks examined. Intended for area-constrained datapaths where single-cycle wide compare is too costly.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per clock; NCH = WIDTH/CHUNK chunks.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned.
- EARLY_EXIT, 1, 1 = finish on first differing chunk; 0 = always scan all NCH chunks (constant latency).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request compare; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  single-cycle pulse; results valid and updated.
- eq  output  1  A == B (last completed compare).
- gt  output  1  A > B.
- lt  output  1  A < B.
- cycles  output  $clog2(NCH+1)  chunks examined in last compare (1..NCH).

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; busy=0, done=0, eq=0, gt=0, lt=0, cycles=0; shift registers cleared.
- Reset mid-compare aborts it. No done is issued and results return to 0.
- Results stay all-zero until the first completion. After that, exactly one of eq/gt/lt is 1.

FSM states: IDLE, SCAN.
- IDLE:
  - start=1 at edge E0 captures a, b into internal shift registers, clears the chunk counter, and goes to SCAN.
  - busy=1 from E0.
- SCAN, edge En (n = 1..NCH): compare the top CHUNK bits of the A and B shift registers (chunk n).
  - Signed handling: when SIGNED=1, the operand MSB is inverted on both operands in chunk 1 only (offset-binary), then an unsigned chunk compare is used.
  - Chunks differ, and no decision has been latched yet: latch gt/lt for the result.
  - Chunks differ, EARLY_EXIT=1: complete at En.
  - All NCH chunks equal: result eq; complete at E_NCH.
  - EARLY_EXIT=0: the first differing chunk decides the result; later chunks are ignored. Completion is always at E_NCH.
  - Chunks not yet deciding: shift both registers left by CHUNK.
- Completion at edge Ek:
  - eq/gt/lt and cycles=k are updated.
  - done=1 for exactly the following cycle; busy=0; state=IDLE.
- Latency: done is visible k cycles after the start edge.
  - k = index of the first differing chunk, or NCH when the operands are equal or EARLY_EXIT=0.
- Previous eq/gt/lt/cycles are held unchanged while busy; they update only at completion.
- start while busy: ignored; no queuing.
- a/b changes while busy: no effect.
- start high in the done cycle (state already IDLE): accepted. Back-to-back throughput is one compare per k+1 cycles.
- start held high continuously: a new compare is accepted every time IDLE is reached.
- All internal arithmetic is unsigned on CHUNK-bit slices; no carries cross chunks.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
1. Equal operands: a=0x1234, b=0x1234, start 1 cycle -> busy for 4 cycles, then done pulse with eq=1, gt=0, lt=0, cycles=4.
2. Early exit, unsigned vs signed:
   - SIGNED=0: a=0x8000, b=0x7FFF -> done 1 cycle after start, gt=1, cycles=1.
   - SIGNED=1: same operands -> lt=1, cycles=1.
   - SIGNED=1: a=0xFFFF, b=0xFFFE -> gt=1, cycles=4.
3. Last-chunk decision and held results:
   - a=0x12F0, b=0x12F1 -> lt=1, cycles=4.
   - Then a=0x2000, b=0x1FFF -> during busy the outputs still show lt=1/cycles=4; at done, gt=1, cycles=1.
4. EARLY_EXIT=0: a=0xF000, b=0x0000 -> done exactly 4 cycles after start, gt=1, cycles=4. A later difference (a=0xF001, b=0x0002) does not override: still gt=1.
5. Handshake robustness:
   - start pulse while busy -> ignored; single done.
   - a/b toggled every cycle during busy -> result matches the captured values.
   - start asserted in the done cycle -> second compare accepted, busy=1 next cycle.
6. Reset: rst=1 for 1 cycle at the 2nd SCAN cycle of a compare -> next cycle busy=0, done=0, eq=gt=lt=0, cycles=0; no done pulse follows. A subsequent compare of a=0x0001, b=0x0002 gives lt=1, cycles=4.
